// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard receiver:
//                frame FSM state encoding and the special byte values used by
//                the scan-code decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Prefix bytes
  localparam logic [7:0] c_byte_e0 = 8'hE0;
  localparam logic [7:0] c_byte_f0 = 8'hF0;

  // Keyboard status / response bytes that never form a key event
  localparam logic [7:0] c_byte_00 = 8'h00;
  localparam logic [7:0] c_byte_aa = 8'hAA;
  localparam logic [7:0] c_byte_ee = 8'hEE;
  localparam logic [7:0] c_byte_fa = 8'hFA;
  localparam logic [7:0] c_byte_fe = 8'hFE;
  localparam logic [7:0] c_byte_ff = 8'hFF;

  // True for bytes that are keyboard status/responses rather than scan codes
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == c_byte_00) || (b == c_byte_aa) || (b == c_byte_ee) ||
           (b == c_byte_fa) || (b == c_byte_fe) || (b == c_byte_ff);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : Two-flop synchronizer followed by a glitch filter for one
//                PS/2 line. The filtered level only follows the input after
//                FILTER_LEN consecutive disagreeing samples. Emits a one-cycle
//                pulse on every filtered 1->0 transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_line,
  output logic o_fall
);

  localparam int c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_fall;

  // Bring the asynchronous line into the clk domain; idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the filtered level only after a full run of disagreeing samples;
  // any agreeing sample restarts the run, so short glitches vanish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_fall  <= r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver. Filters the keyboard clock, frames
//                11-bit PS/2 words (start, 8 data LSB-first, odd parity,
//                stop), flags parity/stop/timeout errors and decodes E0/F0
//                prefixed scan codes into key events.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       raw_strobe,
  output logic [7:0] raw_byte,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic              w_fall;
  logic              r_data_s1;
  logic              r_data_s2;
  ps2_state_t        r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_par;
  logic [c_to_w-1:0] r_to_cnt;
  logic              r_ext;
  logic              r_rel;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_line  (ps2_kbd_clk),
    .o_fall  (w_fall)
  );

  // Data line only needs synchronizing; it is sampled at filtered clock edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_data_s1 <= ps2_kbd_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // Frame FSM, timeout supervisor and scan-code decoder with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      raw_strobe   <= 1'b0;
      raw_byte     <= '0;
      key_strobe   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      raw_strobe <= 1'b0;
      key_strobe <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // A high data bit at an edge is line noise, not a start bit
          r_to_cnt <= '0;
          if (w_fall && !r_data_s2) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
          end
        end

        default: begin
          if (w_fall) begin
            r_to_cnt <= '0;
            case (r_state)
              ST_DATA: begin
                r_shift <= {r_data_s2, r_shift[7:1]};
                r_par   <= r_par ^ r_data_s2;
                if (r_bit_cnt == 3'd7) begin
                  r_state <= ST_PARITY;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                end
              end

              ST_PARITY: begin
                r_par   <= r_par ^ r_data_s2;
                r_state <= ST_STOP;
              end

              ST_STOP: begin
                r_state <= ST_IDLE;
                if (!r_data_s2) begin
                  // A bad stop bit outranks a bad parity bit
                  frame_err <= 1'b1;
                  r_ext     <= 1'b0;
                  r_rel     <= 1'b0;
                end else if (!r_par) begin
                  parity_err <= 1'b1;
                  r_ext      <= 1'b0;
                  r_rel      <= 1'b0;
                end else begin
                  raw_strobe <= 1'b1;
                  raw_byte   <= r_shift;
                  if (r_shift == c_byte_e0) begin
                    r_ext <= 1'b1;
                  end else if (r_shift == c_byte_f0) begin
                    r_rel <= 1'b1;
                  end else if (is_status_byte(r_shift)) begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                  end else begin
                    key_strobe   <= 1'b1;
                    key_code     <= r_shift;
                    key_extended <= r_ext;
                    key_released <= r_rel;
                    r_ext        <= 1'b0;
                    r_rel        <= 1'b0;
                  end
                end
              end

              default: r_state <= ST_IDLE;
            endcase
          end else if (r_to_cnt == c_to_last) begin
            // Keyboard stopped clocking mid-frame: abandon it
            frame_err <= 1'b1;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_state   <= ST_IDLE;
            r_to_cnt  <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required before the filtered PS/2 clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8192, meaning clk cycles without a filtered falling edge before an in-progress frame is aborted.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port ps2_kbd_clk, input, 1, PS/2 keyboard clock from the io stage, which idles high and is asynchronous to clk.
REQ-006 SHALL have port ps2_kbd_data, input, 1, PS/2 keyboard data from the io stage, asynchronous to clk.
REQ-007 SHALL have port raw_strobe, output, 1, a one-cycle pulse that marks a valid received byte.
REQ-008 SHALL have port raw_byte, output, 8, the last valid received byte, held until the next raw_strobe.
REQ-009 SHALL have port key_strobe, output, 1, a one-cycle pulse that marks a decoded key event.
REQ-010 SHALL have port key_code, output, 8, the scan code of the last key event, held until the next key_strobe.
REQ-011 SHALL have port key_extended, output, 1, set when the last key event was preceded by E0.
REQ-012 SHALL have port key_released, output, 1, set when the last key event was preceded by F0.
REQ-013 SHALL have port parity_err, output, 1, a one-cycle pulse on a frame with bad parity.
REQ-014 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-015 SHALL pass ps2_kbd_clk and ps2_kbd_data each through a 2-flop synchronizer.
REQ-016 SHALL change the filtered clock only after FILTER_LEN consecutive synchronized samples differ from its current level; shorter glitches are ignored.
REQ-017 SHALL define a falling edge as a filtered-clock 1->0 transition and SHALL sample synchronized data only on that cycle.
REQ-018 SHALL use frame FSM states IDLE, DATA, PARITY and STOP.
REQ-019 IDLE: a falling edge with data=0 SHALL go to DATA with bit count 0 and parity accumulator 0; a falling edge with data=1 SHALL stay in IDLE with no error.
REQ-020 DATA: each falling edge SHALL shift data in LSB-first; after the 8th bit the FSM SHALL go to PARITY.
REQ-021 PARITY: the falling edge SHALL record the parity bit; parity is good when the XOR of 8 data bits and the parity bit equals 1 (odd parity); the FSM then goes to STOP.
REQ-022 STOP on the falling edge with data=1 and good parity: SHALL assert raw_strobe for one cycle, starting the cycle after that edge, with raw_byte updated on the same cycle.
REQ-023 STOP with data=1 and bad parity: SHALL pulse parity_err; SHALL NOT pulse raw_strobe.
REQ-024 STOP with data=0: SHALL pulse frame_err only, even if parity is also bad.
REQ-025 Every STOP outcome SHALL return the FSM to IDLE.
REQ-026 Timeout: when not in IDLE and TIMEOUT_CYCLES clk cycles pass without a falling edge, SHALL pulse frame_err and return to IDLE; the counter restarts on every falling edge and holds at 0 in IDLE.
REQ-027 Decoder, byte E0: SHALL set the ext flag; no key_strobe.
REQ-028 Decoder, byte F0: SHALL set the rel flag; no key_strobe.
REQ-029 Decoder, bytes 00, AA, EE, FA, FE, FF: SHALL produce raw_strobe only and clear both flags.
REQ-030 Decoder, any other byte: SHALL pulse key_strobe in the same cycle as raw_strobe, with key_code=byte, key_extended=ext, key_released=rel, then clear both flags.
REQ-031 Prefix sequence E0 F0 xx SHALL yield key_extended=1 and key_released=1; a repeated prefix SHALL leave its flag set.
REQ-032 parity_err and frame_err SHALL clear both prefix flags.
REQ-033 No output SHALL pulse for longer than one cycle per frame.

Reset
REQ-034 On reset_n low: FSM to IDLE; synchronizer flops and filtered clock to 1; bit, filter and timeout counters to 0; prefix flags to 0.
REQ-035 On reset_n low: all outputs to 0.
REQ-036 A frame interrupted by reset SHALL be discarded silently, with no error pulse after release.

Structure
REQ-037 A shared package ps2_pkg SHALL hold the FSM state enum and the byte constants E0, F0, 00, AA, EE, FA, FE and FF.
REQ-038 Synchronizer plus glitch filter SHALL be a sub-module ps2_line_filter, instantiated for the clock line, with an edge-detect output.

Verification
REQ-039 Send 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> one raw_strobe, raw_byte=1C, key_strobe, key_code=1C, key_extended=0, key_released=0.
REQ-040 Send E0, F0, 0x75 -> key_strobe only on the third byte, key_code=75, key_extended=1, key_released=1; no key_strobe on E0 or F0.
REQ-041 Send 0x1C with the parity bit inverted -> parity_err pulses once, no raw_strobe, no key_strobe; a following valid 0x1C is decoded normally.
REQ-042 Drive 5 clock edges then hold ps2_kbd_clk high for TIMEOUT_CYCLES+1 cycles -> exactly one frame_err pulse, FSM in IDLE, next frame 0xAA -> raw_strobe only.
REQ-043 Inject 2-cycle low glitches on ps2_kbd_clk at FILTER_LEN=4 during a 0x29 frame -> byte received as 29, no errors.
REQ-044 Assert reset_n low mid-frame after 4 data bits, release, send 0x16 -> no error pulses, key_code=16.
